// File: rtl/l2_evict_buffer_pkg.sv
// rtl/l2_evict_buffer_pkg.sv - shared types and helpers for the L2 eviction buffer
package l2_evict_buffer_pkg;

  localparam int LINE_BITS        = 1024;
  localparam int TAG_BITS         = 9;
  localparam int LINE_OFFSET_BITS = 7;

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [TAG_BITS-1:0]  tag_t;

  typedef enum logic [2:0] {
    IDLE,
    MEM_READ,
    DRAIN,
    RESP,
    GAP
  } state_t;

  // Line tag of a byte address; the low offset bits select a byte inside the line.
  function automatic tag_t addr_tag(input logic [15:0] addr);
    return addr[15:LINE_OFFSET_BITS];
  endfunction

  // Line-aligned memory address for a tag.
  function automatic logic [15:0] tag_addr(input tag_t tag);
    return {tag, {LINE_OFFSET_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/l2_evict_buffer_store.sv
// rtl/l2_evict_buffer_store.sv - circular line FIFO with parallel tag lookup
module l2_evict_buffer_store
  import l2_evict_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  tag_t          lookup_tag,
  output logic          hit,
  output logic [PW-1:0] hit_index,
  output line_t         hit_data,
  input  logic          push,
  input  tag_t          push_tag,
  input  line_t         push_data,
  input  logic          pop,
  input  logic          coalesce,
  input  line_t         coalesce_data,
  output tag_t          head_tag,
  output line_t         head_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0] valid;
  tag_t             tags [DEPTH];
  line_t            data [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Parallel tag compare; coalescing upstream keeps matches to at most one entry.
  always_comb begin
    hit       = 1'b0;
    hit_index = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (tags[i] == lookup_tag)) begin
        hit       = 1'b1;
        hit_index = PW'(i);
      end
    end
  end

  assign hit_data  = data[hit_index];
  assign head_tag  = tags[head];
  assign head_data = data[head];
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);

  // Entry bookkeeping: valid bits, tags, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tags[i] <= '0;
      end
    end else begin
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= ptr_next(head);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        tags[tail]  <= push_tag;
        tail        <= ptr_next(tail);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Line payloads carry no reset; an entry's data only matters while it is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data[tail] <= push_data;
    end else if (coalesce) begin
      data[hit_index] <= coalesce_data;
    end
  end

endmodule

// File: rtl/l2_evict_buffer.sv
// rtl/l2_evict_buffer.sv - write-back eviction buffer between L2 and physical memory
module l2_evict_buffer
  import l2_evict_buffer_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   u_read,
  input  logic                   u_write,
  input  logic [15:0]            u_address,
  input  logic [1023:0]          u_wdata,
  output logic                   u_resp,
  output logic [1023:0]          u_rdata,
  output logic                   pmem_read,
  output logic                   pmem_write,
  output logic [15:0]            pmem_address,
  output logic [1023:0]          pmem_wdata,
  input  logic                   pmem_resp,
  input  logic [1023:0]          pmem_rdata,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int PW = $clog2(DEPTH);

  state_t        state;
  tag_t          req_tag;
  logic          hit;
  logic [PW-1:0] hit_index;
  line_t         hit_data;
  tag_t          head_tag;
  line_t         head_data;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          coalesce;

  assign req_tag = addr_tag(u_address);

  // Store updates happen on the same edge the FSM decides on them; a read always wins over a write.
  assign push     = (state == IDLE) && !u_read && u_write && !hit && !full;
  assign coalesce = (state == IDLE) && !u_read && u_write && hit;
  assign pop      = (state == DRAIN) && pmem_resp;

  l2_evict_buffer_store #(
    .DEPTH(DEPTH)
  ) u_store (
    .clk          (clk),
    .rst          (rst),
    .lookup_tag   (req_tag),
    .hit          (hit),
    .hit_index    (hit_index),
    .hit_data     (hit_data),
    .push         (push),
    .push_tag     (req_tag),
    .push_data    (u_wdata),
    .pop          (pop),
    .coalesce     (coalesce),
    .coalesce_data(u_wdata),
    .head_tag     (head_tag),
    .head_data    (head_data),
    .full         (full),
    .empty        (empty),
    .count        (buf_count)
  );

  // Control FSM with registered handshake outputs on both sides.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      u_resp       <= 1'b0;
      u_rdata      <= '0;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (u_read) begin
            if (hit) begin
              u_rdata <= hit_data;
              u_resp  <= 1'b1;
              state   <= RESP;
            end else begin
              // The missing line differs from every buffered one, so it may pass them.
              pmem_read    <= 1'b1;
              pmem_address <= tag_addr(req_tag);
              state        <= MEM_READ;
            end
          end else if (u_write && (hit || !full)) begin
            u_resp <= 1'b1;
            state  <= RESP;
          end else if (u_write || !empty) begin
            // Full-buffer writes stay pending and are re-evaluated after this drain.
            pmem_write   <= 1'b1;
            pmem_address <= tag_addr(head_tag);
            pmem_wdata   <= head_data;
            state        <= DRAIN;
          end
        end
        MEM_READ: begin
          if (pmem_resp) begin
            u_rdata   <= pmem_rdata;
            pmem_read <= 1'b0;
            u_resp    <= 1'b1;
            state     <= RESP;
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            pmem_write <= 1'b0;
            state      <= GAP;
          end
        end
        RESP: begin
          u_resp <= 1'b0;
          state  <= GAP;
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_evict_buffer.sv
// tb/tb_l2_evict_buffer.sv - self-checking bench for the L2 eviction buffer
module tb_l2_evict_buffer;
  import l2_evict_buffer_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          u_read;
  logic          u_write;
  logic [15:0]   u_address;
  logic [1023:0] u_wdata;
  logic          u_resp;
  logic [1023:0] u_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  logic [1023:0] pmem_wdata;
  logic          pmem_resp;
  logic [1023:0] pmem_rdata;
  logic [1:0]    buf_count;

  l2_evict_buffer #(.DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .u_read      (u_read),
    .u_write     (u_write),
    .u_address   (u_address),
    .u_wdata     (u_wdata),
    .u_resp      (u_resp),
    .u_rdata     (u_rdata),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_resp   (pmem_resp),
    .pmem_rdata  (pmem_rdata),
    .buf_count   (buf_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_reads = 0;

  typedef struct {
    logic [8:0] tag;
    line_t      data;
  } ent_t;

  ent_t  q[$];
  line_t mem [512];

  line_t t_rd;
  int    t_cnt;
  bit    t_saw;
  int    t_lat;

  function automatic line_t rand_line();
    line_t r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic line_t init_line(input int l);
    line_t r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = {16'hC0DE ^ 16'(i), 7'd0, 9'(l)};
    return r;
  endfunction

  function automatic int find(input logic [8:0] tag);
    for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_line(input string nm, input line_t act, input line_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got ..%h, expected ..%h", nm, act[127:0], exp[127:0]);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_u_resp"}, u_resp, 0);
    chk_line({nm, "_u_rdata"}, u_rdata, '0);
    chk({nm, "_pmem_read"}, pmem_read, 0);
    chk({nm, "_pmem_write"}, pmem_write, 0);
    chk({nm, "_pmem_address"}, pmem_address, 0);
    chk_line({nm, "_pmem_wdata"}, pmem_wdata, '0);
    chk({nm, "_buf_count"}, buf_count, 0);
  endtask

  // One upstream transaction; the reference queue/memory are updated on completion.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input line_t wd);
    int    r0;
    int    idx;
    bit    got;
    line_t exp;
    r0 = n_reads;
    got = 0;
    t_lat = 0;
    u_address = addr;
    u_wdata = wd;
    u_write = wr;
    u_read = !wr;
    while (!got && t_lat < 3000) begin
      @(negedge clk);
      t_lat++;
      got = u_resp;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: got no u_resp after %0d cycles, expected one", t_lat);
      u_read = 0;
      u_write = 0;
      return;
    end
    t_rd = u_rdata;
    t_cnt = int'(buf_count);
    t_saw = (n_reads != r0);
    u_read = 0;
    u_write = 0;
    idx = find(addr[15:7]);
    if (wr) begin
      if (idx >= 0) q[idx].data = wd;
      else q.push_back('{addr[15:7], wd});
    end else begin
      exp = (idx >= 0) ? q[idx].data : mem[addr[15:7]];
      chk_line("model_rdata", t_rd, exp);
      chk("model_pmem_read", longint'(t_saw), longint'(idx < 0));
    end
    chk("model_count", t_cnt, q.size());
    @(negedge clk);
    chk("resp_pulse_width", u_resp, 0);
  endtask

  task automatic wait_empty(input string nm);
    int w;
    w = 0;
    while ((buf_count != 0 || pmem_write) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_buf_count"}, buf_count, 0);
    chk({nm, "_model_size"}, q.size(), 0);
  endtask

  // Behavioural physical memory: random latency, one-cycle response, drain-order check.
  initial begin : memory_model
    bit         busy;
    int         lat;
    logic [8:0] line;
    busy = 0;
    lat = 0;
    pmem_resp = 0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pmem_resp = 0;
        busy = 0;
      end else if (pmem_resp) begin
        pmem_resp = 0;
      end else if (pmem_read || pmem_write) begin
        n_cmp++;
        if ((pmem_read && pmem_write) || (pmem_address[6:0] != 7'd0)) begin
          n_bad++;
          $display("FAIL pmem_protocol: got rd=%0d wr=%0d addr=%h, expected one request on a line address",
                   pmem_read, pmem_write, pmem_address);
        end
        if (!busy) begin
          busy = 1;
          lat = $urandom_range(2, 6);
        end
        lat--;
        if (lat == 0) begin
          busy = 0;
          line = pmem_address[15:7];
          if (pmem_write) begin
            if (q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL drain_unexpected: got write to %h, expected empty buffer", pmem_address);
            end else begin
              chk("drain_address", pmem_address, longint'(tag_addr(q[0].tag)));
              chk_line("drain_data", pmem_wdata, q[0].data);
              void'(q.pop_front());
            end
            mem[line] = pmem_wdata;
          end else begin
            pmem_rdata = mem[line];
            n_reads++;
          end
          pmem_resp = 1;
        end
      end
    end
  end

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    int          wsel;
    int          rsel;
    int          cnt;
    bit          pread;
    int          lat;
  } vec_t;

  vec_t  tbl [9];
  line_t dl [4];

  initial begin : main
    line_t exp;
    int    w;
    for (int i = 0; i < 512; i++) mem[i] = init_line(i);
    for (int i = 0; i < 4; i++) dl[i] = rand_line();

    // rsel: -1 no data check, 0..3 bench data word, 4 initial memory contents of the line
    tbl[0] = '{1'b1, 16'h0080, 0, -1, 1, 1'b0, 0};
    tbl[1] = '{1'b1, 16'h0080, 1, -1, 1, 1'b0, 2};
    tbl[2] = '{1'b0, 16'h00C4, 0,  1, 1, 1'b0, 2};
    tbl[3] = '{1'b1, 16'h0100, 2, -1, 2, 1'b0, 2};
    tbl[4] = '{1'b0, 16'h1000, 0,  4, 2, 1'b1, 0};
    tbl[5] = '{1'b1, 16'h0180, 3, -1, 2, 1'b0, 0};
    tbl[6] = '{1'b0, 16'h0104, 0,  2, 2, 1'b0, 2};
    tbl[7] = '{1'b0, 16'h0180, 0,  3, 2, 1'b0, 2};
    tbl[8] = '{1'b0, 16'h0080, 0,  1, 2, 1'b1, 0};

    u_read = 0;
    u_write = 0;
    u_address = '0;
    u_wdata = '0;
    rst = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_txn(tbl[i].wr, tbl[i].addr, dl[tbl[i].wsel]);
      chk($sformatf("vec%0d_count", i), t_cnt, tbl[i].cnt);
      chk($sformatf("vec%0d_pmem_read", i), t_saw, tbl[i].pread);
      if (tbl[i].lat != 0) chk($sformatf("vec%0d_latency", i), t_lat, tbl[i].lat);
      if (tbl[i].rsel >= 0) begin
        exp = (tbl[i].rsel == 4) ? init_line(int'(tbl[i].addr[15:7])) : dl[tbl[i].rsel];
        chk_line($sformatf("vec%0d_rdata", i), t_rd, exp);
      end
    end
    wait_empty("table_drain");

    for (int n = 0; n < 200; n++) begin
      logic [15:0] a;
      a = {9'((($urandom_range(0, 7) * 37) + 3) % 512), 7'($urandom)};
      repeat ($urandom_range(0, 4)) @(negedge clk);
      do_txn(1'($urandom_range(0, 1)), a, rand_line());
    end
    wait_empty("random_drain");

    do_txn(1'b1, 16'h3080, rand_line());
    w = 0;
    while (!pmem_write && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("rst_test_drain_started", pmem_write, 1);
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    check_reset_outputs("rst_mid_drain");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    do_txn(1'b0, 16'h3080, '0);
    chk("rst_reread_pmem_read", t_saw, 1);
    chk_line("rst_reread_data", t_rd, init_line(9'h061));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
